// File: rtl/clk_char_pkg.sv
// clk_char_pkg: shared types, default widths and latency helper for the clock characteriser
package clk_char_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int SYNC_STAGES_DEF = 2;
    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
    function automatic int pipe_lat(input int stages);
        return stages + 1;
    endfunction
endpackage

// File: rtl/clk_char_monitor_sync_edge_det.sv
// sync_edge_det: sig_in synchroniser plus prev register, producing rise/fall event flags
module sync_edge_det
    import clk_char_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    localparam int LAT = pipe_lat(STAGES);
    // sh[STAGES-1] is the synchroniser output, sh[STAGES] is prev
    logic [LAT-1:0] sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh <= '0;
        else sh <= {sh[LAT-2:0], d};
    end
    assign rise = sh[STAGES-1] & ~sh[STAGES];
    assign fall = ~sh[STAGES-1] & sh[STAGES];
endmodule

// File: rtl/clk_char_monitor.sv
// clk_char_monitor: measures period, high/low time and ref_tick phase of an async waveform in clk cycles
module clk_char_monitor
    import clk_char_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    input  logic             ref_tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W-1:0] phase,
    output logic             phase_vld,
    output logic             res_vld,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, ph_cnt;
    logic ph_arm, en_d, rise, fall, sat, res, lat_hi, set_ovf;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sig_in),
        .rise (rise),
        .fall (fall)
    );

    assign sat = (cnt == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        cnt_d = cnt + ONE;
        res = 1'b0;
        lat_hi = 1'b0;
        set_ovf = 1'b0;
        if (!en || state == IDLE) begin
            state_d = en ? ARM : IDLE;
            cnt_d = '0;
        end else if (sat) begin
            // a stuck or too-slow waveform: restart cleanly from the next rise
            state_d = ARM;
            cnt_d = '0;
            set_ovf = 1'b1;
        end else begin
            case (state)
                ARM: begin
                    state_d = rise ? HIGH : ARM;
                    cnt_d = rise ? ONE : cnt + ONE;
                end
                HIGH: begin
                    state_d = fall ? LOW : HIGH;
                    lat_hi = fall;
                end
                default: begin
                    state_d = rise ? HIGH : LOW;
                    cnt_d = rise ? ONE : cnt + ONE;
                    res = rise;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            en_d <= 1'b0;
            period <= '0;
            high_time <= '0;
            low_time <= '0;
            phase <= '0;
            phase_vld <= 1'b0;
            res_vld <= 1'b0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_d;
            en_d <= en;
            res_vld <= res;
            if (lat_hi) high_time <= cnt;
            if (res) begin
                period <= cnt;
                low_time <= cnt - high_time;
                phase_vld <= ph_arm;
                if (ph_arm) phase <= (ph_cnt == MAX) ? MAX : ph_cnt + ONE;
            end
            if (set_ovf) ovf <= 1'b1;
            else if (en && !en_d) ovf <= 1'b0;
        end
    end

    // the rise captures the old count before a coincident ref_tick reloads it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt <= '0;
            ph_arm <= 1'b0;
        end else if (!en) begin
            ph_arm <= 1'b0;
        end else if (ref_tick) begin
            ph_cnt <= '0;
            ph_arm <= 1'b1;
        end else if (res) begin
            ph_arm <= 1'b0;
        end else if (ph_arm && ph_cnt != MAX) begin
            ph_cnt <= ph_cnt + ONE;
        end
    end
endmodule

// File: tb/tb_clk_char_monitor.sv
// tb_clk_char_monitor: directed checks of clk_char_monitor with hand-computed expectations
module tb_clk_char_monitor;
    import clk_char_pkg::*;
    localparam int W = 8;
    logic clk = 0, rst_n = 0, en = 0, sig_in = 0, ref_tick = 0;
    logic [W-1:0] period, high_time, low_time, phase;
    logic phase_vld, res_vld, ovf;
    int checks = 0, errors = 0, cyc = 0, last = 0, gap = 0, rv_cnt = 0, snap = 0;

    clk_char_monitor #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sig_in   (sig_in),
        .ref_tick (ref_tick),
        .period   (period),
        .high_time(high_time),
        .low_time (low_time),
        .phase    (phase),
        .phase_vld(phase_vld),
        .res_vld  (res_vld),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (res_vld) begin
            rv_cnt++;
            gap = cyc - last;
            last = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // edges are driven 2 ns after posedge; high for hi samples then low for lo samples
    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            sig_in = 1;
            repeat (hi) @(posedge clk);
            #2 sig_in = 0;
            repeat (lo) @(posedge clk);
            #2;
        end
    endtask

    task automatic low_hold(input int lo);
        sig_in = 0;
        repeat (lo) @(posedge clk);
        #2;
    endtask

    task automatic rise_to_result();
        sig_in = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_low", low_time, 0);
        chk("rst_phase", phase, 0);
        chk("rst_flags", {phase_vld, res_vld, ovf}, 0);
        @(posedge clk);
        #2 rst_n = 1;
        en = 1;
        repeat (3) @(posedge clk);
        #2;
        wave(3, 7, 1);
        chk("first_rise_no_res", rv_cnt, 0);
        wave(3, 7, 2);
        rise_to_result();
        chk("basic_vld", res_vld, 1);
        chk("basic_period", period, 10);
        chk("basic_high", high_time, 3);
        chk("basic_low", low_time, 7);
        chk("basic_phase_vld", phase_vld, 0);
        #1 low_hold(7);
        chk("basic_count", rv_cnt, 3);
        chk("basic_gap", gap, 10);
        chk("basic_vld_pulse", res_vld, 0);
        wave(3, 2, 2);
        rise_to_result();
        chk("duty_period", period, 5);
        chk("duty_high", high_time, 3);
        chk("duty_low", low_time, 2);
        chk("duty_sum", W'(high_time + low_time), 5);
        chk("duty_gap", gap, 5);
        #1 sig_in = 0;
        repeat (2) @(posedge clk);
        #2 ref_tick = 1;
        @(posedge clk);
        #2 ref_tick = 0;
        repeat (4) @(posedge clk);
        #2;
        rise_to_result();
        chk("phase_val", phase, 7);
        chk("phase_vld", phase_vld, 1);
        chk("phase_period", period, 10);
        chk("phase_low", low_time, 7);
        #1 low_hold(7);
        rise_to_result();
        chk("phase_hold_val", phase, 7);
        chk("phase_hold_vld", phase_vld, 0);
        chk("phase_hold_res", res_vld, 1);
        #1 low_hold(7);
        sig_in = 1;
        repeat (4) @(posedge clk);
        #2 en = 0;
        snap = rv_cnt;
        wave(3, 7, 2);
        chk("en_drop_no_res", rv_cnt, snap);
        chk("en_drop_period", period, 10);
        chk("en_drop_high", high_time, 3);
        chk("en_drop_low", low_time, 7);
        chk("en_drop_state", dut.state, IDLE);
        en = 1;
        repeat (2) @(posedge clk);
        #2 sig_in = 1;
        snap = rv_cnt;
        repeat (300) @(posedge clk);
        #2;
        chk("sat_ovf", ovf, 1);
        chk("sat_no_res", rv_cnt, snap);
        chk("sat_state", dut.state, ARM);
        low_hold(7);
        wave(3, 7, 1);
        rise_to_result();
        chk("resume_vld", res_vld, 1);
        chk("resume_period", period, 10);
        chk("resume_high", high_time, 3);
        chk("resume_ovf_sticky", ovf, 1);
        #1 en = 0;
        repeat (2) @(posedge clk);
        #2 en = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("en_toggle_ovf", ovf, 0);
        chk("en_toggle_hold", period, 10);
        #1 low_hold(3);
        sig_in = 1;
        repeat (3) @(posedge clk);
        #2 sig_in = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_state", dut.state, LOW);
        #1 rst_n = 0;
        #1;
        chk("async_rst_results", {period, high_time, low_time, phase}, 0);
        chk("async_rst_flags", {phase_vld, res_vld, ovf}, 0);
        @(posedge clk);
        #2 rst_n = 1;
        repeat (2) @(posedge clk);
        #2;
        snap = rv_cnt;
        wave(3, 7, 1);
        chk("post_rst_first_rise", rv_cnt, snap);
        rise_to_result();
        chk("post_rst_vld", res_vld, 1);
        chk("post_rst_period", period, 10);
        chk("post_rst_low", low_time, 7);
        chk("post_rst_ovf", ovf, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
